lock_arbiter: RTL
=================

// Module: lock_arbiter
// PURPOSE
//  Responder side of the dual-core lock handshake: receives need_lock/release from
//  core0 and core1 and returns a one-hot lock grant to the shared memory.
//  Round-robin fairness via whose_turn; hold-time watchdog revokes a stuck lock.
//  Gates each core's memory write enable so only the lock holder can write.
//  Core0 owns memory port a, core1 owns port b.
// PARAMETERS
//  TIMEOUT  64  max cycles a lock is held before forced revoke (>=2)
//  TO_W     7   watchdog counter width, must hold TIMEOUT
// PORTS
//  clk                input   1  system clock, all state on rising edge
//  rst                input   1  synchronous reset, active-high
//  need_lock          input   2  [i]=core i requests/holds lock (level)
//  release            input   2  [i]=core i releases lock (1-cycle pulse)
//  wren_a_in          input   1  core0 raw write enable, port a
//  wren_b_in          input   1  core1 raw write enable, port b
//  lock               output  2  one-hot grant, registered; 00 = free
//  whose_turn         output  1  core preferred on next tie (0/1), registered
//  finished_storing   output  1  1-cycle pulse when a lock is returned
//  revoked            output  2  1-cycle pulse, [i]=core i lock forcibly taken
//  wren_a             output  1  wren_a_in & lock[0] (combinational)
//  wren_b             output  1  wren_b_in & lock[1] (combinational)
// BEHAVIOUR
//  Reset: lock=00, whose_turn=0, finished_storing=0, revoked=00, state IDLE, cnt=0.
//  States: IDLE, GRANT0, GRANT1, RELEASE (cool-down, 1 cycle).
//  IDLE: need_lock=01 -> GRANT0; 10 -> GRANT1; 11 -> GRANT[whose_turn]; 00 stay.
//   Grant latency 1 cycle: request sampled in cycle n, lock high from n+1.
//  GRANTi: lock[i]=1, cnt increments each cycle from 0.
//   release[i]=1 or need_lock[i]=0 -> RELEASE, finished_storing=1 next cycle.
//   cnt==TIMEOUT-1 with no release -> RELEASE, revoked[i]=1 and
//   finished_storing=1 in the same cycle lock drops.
//   Release and timeout same cycle: release wins, revoked stays 0.
//   release[j] from non-holder j: ignored. Other core's need_lock: waits.
//  Leaving GRANTi: whose_turn <= ~i (other core preferred next).
//  RELEASE: lock=00 for exactly 1 cycle, then IDLE; requests re-evaluated in IDLE,
//   so a waiting core gets lock 2 cycles after holder's release.
//  Revoked core must drop need_lock before re-request; if it keeps it high it
//   competes normally (loses tie since whose_turn points away).
//  lock is never 11; wren_x never high without matching lock bit.
//  Reset mid-grant: lock drops next edge, no finished_storing/revoked pulse.
// STRUCTURE
//  lock_pkg: state encoding localparams (S_IDLE..S_RELEASE), CORE0/CORE1 indices.
//  Sub-module lock_watchdog: TO_W counter, clear/enable inputs, expire output at
//   TIMEOUT-1. FSM, grant regs and write gating stay in lock_arbiter.
// TESTING
//  need_lock=01 at cycle 3 -> lock=01 at cycle 4; wren_a_in=1 passes, wren_b_in=1 blocked.
//  need_lock=11 after reset -> lock=01; release[0] -> lock 00 one cycle, then 10,
//   whose_turn=1 then 0 after core1 releases.
//  Core1 holds, core0 pulses release[0] -> ignored, lock stays 10, no pulses.
//  Core0 holds 64 cycles no release -> revoked=01, finished_storing=1, lock=00,
//   next grant to waiting core1.
//  release[0] on cycle cnt==63 -> revoked=00, finished_storing=1.
//  rst=1 while lock=10 -> lock=00, whose_turn=0 next edge; never lock=11 (assert).

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types for the dual-core lock arbiter: FSM state encoding, core indices
// and the small decode/arbitration helpers used by the arbiter FSM.
package lock_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT0  = 2'd1,
        S_GRANT1  = 2'd2,
        S_RELEASE = 2'd3
    } state_e;

    localparam int CORE0 = 0;
    localparam int CORE1 = 1;

    // One-hot lock vector presented while the FSM sits in a given state.
    function automatic logic [1:0] grant_onehot(input state_e s);
        logic [1:0] g;
        g = 2'b00;
        if (s == S_GRANT0) g[CORE0] = 1'b1;
        if (s == S_GRANT1) g[CORE1] = 1'b1;
        return g;
    endfunction

    function automatic state_e arbitrate(input logic [1:0] need, input logic turn);
        state_e nxt;
        nxt = S_IDLE;
        if (need == 2'b01) nxt = S_GRANT0;
        else if (need == 2'b10) nxt = S_GRANT1;
        else if (need == 2'b11) nxt = turn ? S_GRANT1 : S_GRANT0;
        return nxt;
    endfunction

endpackage

// File: rtl/lock_watchdog.sv
// Hold-time watchdog: counts grant cycles and flags the last permitted one.
module lock_watchdog #(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    import lock_pkg::*;

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) cnt_d = '0;
        else if (enable) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expire = enable && (cnt_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/lock_arbiter.sv
// Responder side of the dual-core lock handshake with round-robin tie-break,
// hold-time revocation and write-enable gating. `release` is a reserved word,
// so the release pulses arrive on release_lock.
module lock_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] need_lock,
    input  logic [1:0] release_lock,
    input  logic       wren_a_in,
    input  logic       wren_b_in,
    output logic [1:0] lock,
    output logic       whose_turn,
    output logic       finished_storing,
    output logic [1:0] revoked,
    output logic       wren_a,
    output logic       wren_b
);
    import lock_pkg::*;

    state_e     state_q, state_d;
    logic [1:0] lock_q, lock_d;
    logic       whose_turn_q, whose_turn_d;
    logic       finished_q, finished_d;
    logic [1:0] revoked_q, revoked_d;
    logic       in_grant;
    logic       holder;
    logic       expire;

    assign in_grant = (state_q == S_GRANT0) || (state_q == S_GRANT1);
    assign holder   = (state_q == S_GRANT1);

    lock_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (!in_grant),
        .enable (in_grant),
        .expire (expire)
    );

    // The cool-down cycle arbitrates like IDLE so lock is low for exactly one
    // cycle and a waiting core is granted two cycles after the release.
    always_comb begin
        state_d      = state_q;
        whose_turn_d = whose_turn_q;
        finished_d   = 1'b0;
        revoked_d    = 2'b00;
        case (state_q)
            S_IDLE, S_RELEASE: state_d = arbitrate(need_lock, whose_turn_q);
            S_GRANT0, S_GRANT1: begin
                if (release_lock[holder] || !need_lock[holder]) begin
                    state_d      = S_RELEASE;
                    finished_d   = 1'b1;
                    whose_turn_d = ~holder;
                end else if (expire) begin
                    state_d           = S_RELEASE;
                    finished_d        = 1'b1;
                    revoked_d[holder] = 1'b1;
                    whose_turn_d      = ~holder;
                end
            end
            default: state_d = S_IDLE;
        endcase
        lock_d = grant_onehot(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            lock_q       <= 2'b00;
            whose_turn_q <= 1'b0;
            finished_q   <= 1'b0;
            revoked_q    <= 2'b00;
        end else begin
            state_q      <= state_d;
            lock_q       <= lock_d;
            whose_turn_q <= whose_turn_d;
            finished_q   <= finished_d;
            revoked_q    <= revoked_d;
        end
    end

    assign lock             = lock_q;
    assign whose_turn       = whose_turn_q;
    assign finished_storing = finished_q;
    assign revoked          = revoked_q;
    assign wren_a           = wren_a_in & lock_q[CORE0];
    assign wren_b           = wren_b_in & lock_q[CORE1];

endmodule
